// File: rtl/rs_alu.sv
// rs_alu: reservation station feeding the combinational integer ALU.
//
// Holds issued integer/branch/JALR ops until both source operands are
// available. Operands are woken by snooping two CDB broadcast ports. Each
// cycle the lowest-index ready entry is sent to the ALU as a registered
// packet.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global ready; low pauses all state changes
//   clear                     mispredict flush; empties every entry
//   issue_*                   new op from the issue unit
//   rs_full                   every entry busy (combinational)
//   cdb0_*, cdb1_*            broadcast ports (ALU, load/store)
//   alu_flag/opcode/val1/val2/rob   registered dispatch packet to the ALU
module rs_alu #(
    parameter int RS_SIZE = 16,
    parameter int RB_W    = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic            issue_valid,
    input  logic [5:0]      issue_opcode,
    input  logic [31:0]     issue_vj,
    input  logic            issue_qj_wait,
    input  logic [RB_W-1:0] issue_qj,
    input  logic [31:0]     issue_vk,
    input  logic            issue_qk_wait,
    input  logic [RB_W-1:0] issue_qk,
    input  logic [RB_W-1:0] issue_rob,
    output logic            rs_full,
    input  logic            cdb0_valid,
    input  logic [RB_W-1:0] cdb0_rob,
    input  logic [31:0]     cdb0_val,
    input  logic            cdb1_valid,
    input  logic [RB_W-1:0] cdb1_rob,
    input  logic [31:0]     cdb1_val,
    output logic            alu_flag,
    output logic [5:0]      alu_opcode,
    output logic [31:0]     alu_val1,
    output logic [31:0]     alu_val2,
    output logic [RB_W-1:0] alu_rob
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage
    logic [RS_SIZE-1:0] busy_reg, busy_next;
    logic [RS_SIZE-1:0] qj_wait_reg, qj_wait_next;
    logic [RS_SIZE-1:0] qk_wait_reg, qk_wait_next;
    logic [5:0]         opcode_reg [RS_SIZE];
    logic [RB_W-1:0]    rob_reg    [RS_SIZE];
    logic [RB_W-1:0]    qj_reg     [RS_SIZE];
    logic [RB_W-1:0]    qk_reg     [RS_SIZE];
    logic [31:0]        vj_reg     [RS_SIZE];
    logic [31:0]        vk_reg     [RS_SIZE];
    logic [31:0]        vj_next    [RS_SIZE];
    logic [31:0]        vk_next    [RS_SIZE];

    // Per-entry wakeup and readiness
    logic [RS_SIZE-1:0] hit_j, hit_k, ready;
    logic [31:0]        wake_vj [RS_SIZE];
    logic [31:0]        wake_vk [RS_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic j0, j1, k0, k1;
            assign j0 = cdb0_valid && (cdb0_rob == qj_reg[gi]);
            assign j1 = cdb1_valid && (cdb1_rob == qj_reg[gi]);
            assign k0 = cdb0_valid && (cdb0_rob == qk_reg[gi]);
            assign k1 = cdb1_valid && (cdb1_rob == qk_reg[gi]);
            assign hit_j[gi]   = j0 || j1;
            assign hit_k[gi]   = k0 || k1;
            // cdb0 takes precedence if both ports carry the same tag
            assign wake_vj[gi] = j0 ? cdb0_val : cdb1_val;
            assign wake_vk[gi] = k0 ? cdb0_val : cdb1_val;
            // Readiness uses only registered state: a wakeup this cycle
            // becomes visible to the next select.
            assign ready[gi]   = busy_reg[gi] && !qj_wait_reg[gi] && !qk_wait_reg[gi];
        end
    endgenerate

    assign rs_full = &busy_reg;

    // Same-cycle forwarding for the op being issued
    logic        fwd_j0, fwd_j1, fwd_k0, fwd_k1;
    assign fwd_j0 = cdb0_valid && (cdb0_rob == issue_qj);
    assign fwd_j1 = cdb1_valid && (cdb1_rob == issue_qj);
    assign fwd_k0 = cdb0_valid && (cdb0_rob == issue_qk);
    assign fwd_k1 = cdb1_valid && (cdb1_rob == issue_qk);

    // Lowest-index free entry and lowest-index ready entry
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             sel_valid, issue_ok;

    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_reg[i]) free_idx = IDX_W'(i);
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                sel_valid = 1'b1;
            end
        end
    end

    assign issue_ok = issue_valid && !rs_full;

    always_comb begin
        busy_next    = busy_reg;
        qj_wait_next = qj_wait_reg;
        qk_wait_next = qk_wait_reg;
        for (int i = 0; i < RS_SIZE; i++) begin
            vj_next[i] = vj_reg[i];
            vk_next[i] = vk_reg[i];
            if (busy_reg[i] && qj_wait_reg[i] && hit_j[i]) begin
                vj_next[i]      = wake_vj[i];
                qj_wait_next[i] = 1'b0;
            end
            if (busy_reg[i] && qk_wait_reg[i] && hit_k[i]) begin
                vk_next[i]      = wake_vk[i];
                qk_wait_next[i] = 1'b0;
            end
        end
        if (sel_valid) busy_next[sel_idx] = 1'b0;
        // The free entry is never the selected one (selected is busy)
        if (issue_ok) begin
            busy_next[free_idx] = 1'b1;
            if (issue_qj_wait && (fwd_j0 || fwd_j1)) begin
                vj_next[free_idx]      = fwd_j0 ? cdb0_val : cdb1_val;
                qj_wait_next[free_idx] = 1'b0;
            end else begin
                vj_next[free_idx]      = issue_vj;
                qj_wait_next[free_idx] = issue_qj_wait;
            end
            if (issue_qk_wait && (fwd_k0 || fwd_k1)) begin
                vk_next[free_idx]      = fwd_k0 ? cdb0_val : cdb1_val;
                qk_wait_next[free_idx] = 1'b0;
            end else begin
                vk_next[free_idx]      = issue_vk;
                qk_wait_next[free_idx] = issue_qk_wait;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_reg   <= '0;
            alu_flag   <= 1'b0;
            alu_opcode <= '0;
            alu_val1   <= '0;
            alu_val2   <= '0;
            alu_rob    <= '0;
        end else if (!rdy_in) begin
            alu_flag <= 1'b0;
        end else if (clear) begin
            busy_reg <= '0;
            alu_flag <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            qj_wait_reg <= qj_wait_next;
            qk_wait_reg <= qk_wait_next;
            for (int i = 0; i < RS_SIZE; i++) begin
                vj_reg[i] <= vj_next[i];
                vk_reg[i] <= vk_next[i];
            end
            if (issue_ok) begin
                opcode_reg[free_idx] <= issue_opcode;
                rob_reg[free_idx]    <= issue_rob;
                qj_reg[free_idx]     <= issue_qj;
                qk_reg[free_idx]     <= issue_qk;
            end
            alu_flag <= sel_valid;
            if (sel_valid) begin
                alu_opcode <= opcode_reg[sel_idx];
                alu_val1   <= vj_reg[sel_idx];
                alu_val2   <= vk_reg[sel_idx];
                alu_rob    <= rob_reg[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Testbench for rs_alu: scoreboard of expected dispatch packets, pushed when
// the stimulus that makes them ready is driven and popped at each dispatch.
module tb_rs_alu;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;

    logic        clk_in, rst_in, rdy_in, clear;
    logic        issue_valid;
    logic [5:0]  issue_opcode;
    logic [31:0] issue_vj, issue_vk;
    logic        issue_qj_wait, issue_qk_wait;
    logic [3:0]  issue_qj, issue_qk, issue_rob;
    logic        rs_full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_rob, cdb1_rob;
    logic [31:0] cdb0_val, cdb1_val;
    logic        alu_flag;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_val1, alu_val2;
    logic [3:0]  alu_rob;

    rs_alu #(.RS_SIZE(16), .RB_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_qj_wait(issue_qj_wait), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk_wait(issue_qk_wait), .issue_qk(issue_qk),
        .issue_rob(issue_rob), .rs_full(rs_full),
        .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_val(cdb0_val),
        .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_val(cdb1_val),
        .alu_flag(alu_flag), .alu_opcode(alu_opcode), .alu_val1(alu_val1),
        .alu_val2(alu_val2), .alu_rob(alu_rob)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [3:0] rob);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.rob = rob;
        exp_q.push_back(e);
    endtask

    // Dispatch monitor: every dispatch must match the oldest expectation,
    // and no dispatch may appear while nothing is expected.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (exp_q.size() == 0) begin
                check("spurious_dispatch", 64'(alu_flag), 64'd0);
            end else if (alu_flag) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("dispatch op=%0d v1=%08h v2=%08h rob=%0d", alu_opcode, alu_val1, alu_val2, alu_rob);
                check("disp_opcode", 64'(alu_opcode), 64'(e.op));
                check("disp_val1",   64'(alu_val1),   64'(e.v1));
                check("disp_val2",   64'(alu_val2),   64'(e.v2));
                check("disp_rob",    64'(alu_rob),    64'(e.rob));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_issue(input logic [5:0] op, input logic [31:0] vj, input logic jw,
                            input logic [3:0] qj, input logic [31:0] vk, input logic kw,
                            input logic [3:0] qk, input logic [3:0] rob);
        issue_valid = 1'b1; issue_opcode = op;
        issue_vj = vj; issue_qj_wait = jw; issue_qj = qj;
        issue_vk = vk; issue_qk_wait = kw; issue_qk = qk;
        issue_rob = rob;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic bcast(input int port, input logic [3:0] tag, input logic [31:0] val);
        if (port == 0) begin
            cdb0_valid = 1'b1; cdb0_rob = tag; cdb0_val = val;
        end else begin
            cdb1_valid = 1'b1; cdb1_rob = tag; cdb1_val = val;
        end
        step();
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        issue_valid = 1'b0; issue_opcode = '0; issue_vj = '0; issue_vk = '0;
        issue_qj_wait = 1'b0; issue_qk_wait = 1'b0; issue_qj = '0; issue_qk = '0; issue_rob = '0;
        cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_val = '0;
        cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_val = '0;

        // Reset state
        idle(2);
        @(negedge clk_in);
        check("rst_flag",   64'(alu_flag),   64'd0);
        check("rst_opcode", 64'(alu_opcode), 64'd0);
        check("rst_val1",   64'(alu_val1),   64'd0);
        check("rst_val2",   64'(alu_val2),   64'd0);
        check("rst_rob",    64'(alu_rob),    64'd0);
        check("rst_full",   64'(rs_full),    64'd0);
        step();
        rst_in = 1'b0;

        // Ready ADD: dispatched one edge after issue, flag drops after
        push(OP_ADD, 32'd5, 32'd7, 4'd3);
        do_issue(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        @(negedge clk_in);
        check("add_not_early", 64'(alu_flag), 64'd0);
        step();
        @(negedge clk_in);
        check("add_flag_high", 64'(alu_flag), 64'd1);
        check("add_sum", 64'(alu_val1 + alu_val2), 64'd12);
        step();
        @(negedge clk_in);
        check("add_flag_drop", 64'(alu_flag), 64'd0);
        step();

        // SUB waiting on tag 2, woken by cdb1
        do_issue(OP_SUB, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
        idle(3);
        push(OP_SUB, 32'd10, 32'd1, 4'd4);
        bcast(1, 4'd2, 32'd10);
        idle(3);

        // Both operands forwarded from cdb0 in the issue cycle
        push(OP_ADD, 32'h8000_0000, 32'h8000_0000, 4'd5);
        cdb0_valid = 1'b1; cdb0_rob = 4'd6; cdb0_val = 32'h8000_0000;
        do_issue(OP_ADD, 32'd0, 1'b1, 4'd6, 32'd0, 1'b1, 4'd6, 4'd5);
        cdb0_valid = 1'b0;
        idle(3);

        // Fill all 16 entries waiting on tag 9; a 17th issue is dropped
        for (int i = 0; i < 16; i++)
            do_issue(6'(10 + i), 32'd0, 1'b1, 4'd9, 32'(200 + i), 1'b0, 4'd0, 4'(i));
        @(negedge clk_in);
        check("full_after_16", 64'(rs_full), 64'd1);
        step();
        do_issue(6'd63, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd7);
        @(negedge clk_in);
        check("full_after_drop", 64'(rs_full), 64'd1);
        step();
        for (int i = 0; i < 16; i++)
            push(6'(10 + i), 32'hABCD_0000, 32'(200 + i), 4'(i));
        bcast(0, 4'd9, 32'hABCD_0000);
        @(negedge clk_in);
        check("full_before_disp", 64'(rs_full), 64'd1);
        step();
        @(negedge clk_in);
        check("full_drop_1st_disp", 64'(rs_full), 64'd0);
        step();
        idle(20);

        // Clear flushes waiting entries; old tags wake nothing
        do_issue(OP_ADD, 32'd0, 1'b1, 4'd11, 32'd1, 1'b0, 4'd0, 4'd1);
        do_issue(OP_ADD, 32'd0, 1'b1, 4'd12, 32'd1, 1'b0, 4'd0, 4'd2);
        do_issue(OP_ADD, 32'd0, 1'b1, 4'd13, 32'd1, 1'b0, 4'd0, 4'd3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk_in);
        check("clear_flag", 64'(alu_flag), 64'd0);
        check("clear_full", 64'(rs_full), 64'd0);
        step();
        bcast(0, 4'd11, 32'd111);
        bcast(1, 4'd12, 32'd222);
        bcast(0, 4'd13, 32'd333);
        idle(3);
        for (int i = 0; i < 14; i++)
            do_issue(6'(20 + i), 32'(100 + i), 1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 4'(i));
        @(negedge clk_in);
        check("clear_freed_entries", 64'(rs_full), 64'd0);
        step();
        for (int i = 0; i < 14; i++)
            push(6'(20 + i), 32'(100 + i), 32'h55, 4'(i));
        bcast(1, 4'd14, 32'h55);
        idle(20);

        // Pause: a ready entry waits while rdy_in is low
        do_issue(OP_SUB, 32'd40, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd9);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("pause_flag", 64'(alu_flag), 64'd0);
            step();
        end
        push(OP_SUB, 32'd40, 32'd2, 4'd9);
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("pause_release_wait", 64'(alu_flag), 64'd0);
        step();
        idle(4);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
